// File: rtl/seven_seg_capture.sv
// Receive side of a multiplexed active-low seven-segment bus: decodes each scanned digit
// back to a hex nibble and assembles complete display frames, flagging bad patterns and stalls.
module seven_seg_capture #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en_n,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    value_valid,
    output logic                    digit_err,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic                    timeout
);

    localparam int unsigned SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SW-1:0] StableLast = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TimeoutLim = TW'(TIMEOUT_CYCLES);

    logic [6:0]              seg_s1_q, seg_s2_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   en_s1_q, en_s2_q, en_prev_q;
    logic [SW-1:0]           stab_q, stab_d;
    logic                    latched_q, latched_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] nib_q, nib_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic                    timeout_q, timeout_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic                    valid_q, valid_d;
    logic                    derr_q, derr_d;
    logic [NUM_DIGITS-1:0]   bmask_q, bmask_d;

    logic [NUM_DIGITS-1:0] en_low;
    logic                  one_low, same, stable, capture, frame_done, tmo_fire;
    logic [IW-1:0]         dig_idx;
    logic [3:0]            dec_nib;
    logic                  dec_blank, dec_err;

    assign en_low     = ~en_s2_q;
    assign one_low    = (en_low != '0) && ((en_low & (en_low - NUM_DIGITS'(1))) == '0);
    assign same       = (seg_s2_q == seg_prev_q) && (en_s2_q == en_prev_q);
    assign stable     = same && one_low;
    // The latch keeps a digit that stays on the bus from being captured again.
    assign capture    = stable && (stab_q == StableLast) && !latched_q;
    assign frame_done = &mask_q;

    always_comb begin
        dig_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (en_low[i]) begin
                dig_idx = IW'(i);
            end
        end
    end

    always_comb begin
        dec_nib   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_s2_q)
            7'b1000000: dec_nib = 4'h0;
            7'b1111001: dec_nib = 4'h1;
            7'b0100100: dec_nib = 4'h2;
            7'b0110000: dec_nib = 4'h3;
            7'b0011001: dec_nib = 4'h4;
            7'b0010010: dec_nib = 4'h5;
            7'b0000010: dec_nib = 4'h6;
            7'b1111000: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0010000: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b0000011: dec_nib = 4'hB;
            7'b1000110: dec_nib = 4'hC;
            7'b0100001: dec_nib = 4'hD;
            7'b0000110: dec_nib = 4'hE;
            7'b0001110: dec_nib = 4'hF;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_err = 1'b1;
        endcase
    end

    always_comb begin
        stab_d    = stab_q;
        latched_d = latched_q;
        if (!stable) begin
            stab_d    = '0;
            latched_d = 1'b0;
        end else begin
            if (stab_q != StableLast) begin
                stab_d = stab_q + SW'(1);
            end
            if (capture) begin
                latched_d = 1'b1;
            end
        end

        tcnt_d    = capture ? '0 : ((tcnt_q == TimeoutLim) ? TimeoutLim : tcnt_q + TW'(1));
        tmo_fire  = !capture && (tcnt_d == TimeoutLim);
        timeout_d = capture ? 1'b0 : (tmo_fire ? 1'b1 : timeout_q);

        mask_d  = mask_q;
        nib_d   = nib_q;
        blank_d = blank_q;
        err_d   = err_q;
        if (frame_done || tmo_fire) begin
            mask_d = '0;
        end
        // Capture is applied last so it survives a same-cycle clear.
        if (capture) begin
            mask_d[dig_idx]           = 1'b1;
            nib_d[4*dig_idx +: 4]     = dec_nib;
            blank_d[dig_idx]          = dec_blank;
            err_d[dig_idx]            = dec_err;
        end

        valid_d = frame_done;
        value_d = frame_done ? nib_q : value_q;
        bmask_d = frame_done ? blank_q : bmask_q;
        derr_d  = frame_done ? |err_q : derr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_s1_q   <= 7'h7F;
            seg_s2_q   <= 7'h7F;
            seg_prev_q <= 7'h7F;
            en_s1_q    <= '1;
            en_s2_q    <= '1;
            en_prev_q  <= '1;
            stab_q     <= '0;
            latched_q  <= 1'b0;
            mask_q     <= '0;
            nib_q      <= '0;
            blank_q    <= '0;
            err_q      <= '0;
            tcnt_q     <= '0;
            timeout_q  <= 1'b0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            derr_q     <= 1'b0;
            bmask_q    <= '0;
        end else begin
            seg_s1_q   <= seg_in;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
            en_s1_q    <= dig_en_n;
            en_s2_q    <= en_s1_q;
            en_prev_q  <= en_s2_q;
            stab_q     <= stab_d;
            latched_q  <= latched_d;
            mask_q     <= mask_d;
            nib_q      <= nib_d;
            blank_q    <= blank_d;
            err_q      <= err_d;
            tcnt_q     <= tcnt_d;
            timeout_q  <= timeout_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            derr_q     <= derr_d;
            bmask_q    <= bmask_d;
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign digit_err   = derr_q;
    assign blank_mask  = bmask_q;
    assign timeout     = timeout_q;

endmodule
